// File: rtl/led_blink_scheduler_pkg.sv
// Shared types and defaults for the LED blink scheduler.
//   state_e   : burst sequencer states
//   DEF_*     : default parameter values
//   idx_w()   : width of a requester index
package led_blink_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam int unsigned DEF_N_REQ     = 4;
  localparam int unsigned DEF_CNT_W     = 4;
  localparam int unsigned DEF_TMR_W     = 8;
  localparam int unsigned DEF_ON_TICKS  = 8;
  localparam int unsigned DEF_OFF_TICKS = 8;
  localparam int unsigned DEF_GAP_TICKS = 16;

  // At least one bit so a single-requester build still has a legal index.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_blink_scheduler_arb.sv
// Round-robin pick: first set request strictly after ptr_i, wrapping around.
//   req_i       : request levels
//   ptr_i       : index of the last granted requester
//   onehot_c_o  : one-hot of the winner (combinational)
//   index_c_o   : binary index of the winner (combinational)
//   valid_c_o   : any request present (combinational)
module led_blink_scheduler_arb
  import led_blink_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ = DEF_N_REQ,
  localparam int unsigned IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] onehot_c_o,
  output logic [IDX_W-1:0] index_c_o,
  output logic             valid_c_o
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down to the nearest so the nearest set request wins.
  always_comb begin
    onehot_c_o = '0;
    index_c_o  = '0;
    valid_c_o  = 1'b0;
    cand       = '0;
    for (int unsigned k = N_REQ; k > 0; k--) begin
      cand = IDX_W'((32'(ptr_i) + k) % N_REQ);
      if (req_i[cand]) begin
        onehot_c_o = N_REQ'(1) << cand;
        index_c_o  = cand;
        valid_c_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// Shares one LED among N_REQ requesters: round-robin grant, then ON/OFF blink
// phases for the granted count, then a guard gap before the next grant.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   req   : level request per requester
//   cnt   : blink count per requester, slice i = cnt[i*CNT_W +: CNT_W]
//   gnt   : one-hot grant pulse when a burst is accepted
//   busy  : burst (including gap) in progress
//   done  : pulse when a burst's gap ends
//   out   : LED drive
module led_blink_scheduler
  import led_blink_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ     = DEF_N_REQ,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned TMR_W     = DEF_TMR_W,
  parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
  parameter int unsigned OFF_TICKS = DEF_OFF_TICKS,
  parameter int unsigned GAP_TICKS = DEF_GAP_TICKS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] cnt,
  output logic [N_REQ-1:0]       gnt,
  output logic                   busy,
  output logic                   done,
  output logic                   out
);

  localparam int unsigned IDX_W = idx_w(N_REQ);

  // Phase reload values, truncated to the timer width.
  localparam logic [TMR_W-1:0] ON_LOAD  = TMR_W'(ON_TICKS - 1);
  localparam logic [TMR_W-1:0] OFF_LOAD = TMR_W'(OFF_TICKS - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD = TMR_W'(GAP_TICKS - 1);

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;
  logic [N_REQ-1:0] gnt_q,   gnt_d;
  logic             done_q,  done_d;
  logic             busy_q,  busy_d;
  logic             out_q;

  logic [N_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0] arb_index;
  logic             arb_valid;
  logic [CNT_W-1:0] cnt_sel;

  led_blink_scheduler_arb #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .onehot_c_o (arb_onehot),
    .index_c_o  (arb_index),
    .valid_c_o  (arb_valid)
  );

  // Count of the requester the arbiter would pick this cycle.
  assign cnt_sel = CNT_W'(cnt >> (32'(arb_index) * CNT_W));

  // Next-state: burst sequencing, timer and remaining-blink bookkeeping.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    rem_d   = rem_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          ptr_d = arb_index;
          gnt_d = arb_onehot;
          rem_d = cnt_sel;
          if (cnt_sel != '0) begin
            state_d = ST_ON;
            timer_d = ON_LOAD;
          end else begin
            state_d = ST_GAP;
            timer_d = GAP_LOAD;
          end
        end
      end
      ST_ON: begin
        if (timer_q == '0) begin
          // Guarded so a zero count can never wrap.
          if (rem_q != '0) rem_d = rem_q - CNT_W'(1);
          state_d = ST_OFF;
          timer_d = OFF_LOAD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_OFF: begin
        if (timer_q == '0) begin
          if (rem_q != '0) begin
            state_d = ST_ON;
            timer_d = ON_LOAD;
          end else begin
            state_d = ST_GAP;
            timer_d = GAP_LOAD;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      ST_GAP: begin
        if (timer_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset starts the pointer at the last index so req[0] wins first.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      rem_q   <= '0;
      ptr_q   <= IDX_W'(N_REQ - 1);
      gnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      out_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      // One cycle behind the sequencer state.
      out_q   <= (state_q == ST_ON);
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign out  = out_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Scoreboard bench for led_blink_scheduler with a burst-level reference model.
module tb_led_blink_scheduler;

  localparam int N   = 4;
  localparam int CW  = 4;
  localparam int ON  = 4;
  localparam int OFF = 4;
  localparam int GAP = 8;
  localparam int P   = ON + OFF;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*CW-1:0] cnt;
  logic [N-1:0]    gnt;
  logic            busy;
  logic            done;
  logic            out;

  always #5 clk = ~clk;

  led_blink_scheduler #(
    .N_REQ     (N),
    .CNT_W     (CW),
    .TMR_W     (8),
    .ON_TICKS  (ON),
    .OFF_TICKS (OFF),
    .GAP_TICKS (GAP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .cnt   (cnt),
    .gnt   (gnt),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  typedef struct {
    int           cyc;
    logic [N-1:0] oh;
  } gexp_t;

  gexp_t gq[$];
  int    dq[$];
  gexp_t ge;
  int    de;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_g = 0;
  int last_d = 0;

  // Reference model: one burst at a time, described by grant time and count.
  bit           m_active = 1'b0;
  int           m_ptr    = N - 1;
  int           m_g      = 0;
  int           m_c      = 0;
  int           m_end    = 0;
  int           m_d      = 0;
  int           mi       = 0;
  bit           m_found  = 1'b0;
  logic [N-1:0] moh;
  bit           exp_out  = 1'b0;
  bit           exp_busy = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 1'b0;
      m_ptr    = N - 1;
      exp_out  = 1'b0;
      exp_busy = 1'b0;
      gq.delete();
      dq.delete();
    end else begin
      cyc++;
      // LED was lit during the cycle that just ended if it fell in an ON phase.
      exp_out = 1'b0;
      if (m_active) begin
        m_d = cyc - 1 - m_g;
        if (m_d >= 0 && m_d < m_c * P && (m_d % P) < ON) exp_out = 1'b1;
      end
      if (m_active && cyc == m_end) begin
        dq.push_back(cyc);
        m_active = 1'b0;
      end else if (!m_active && req != '0) begin
        m_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
          if (!m_found) begin
            mi = (m_ptr + k) % N;
            if (((req >> mi) & N'(1)) != '0) m_found = 1'b1;
          end
        end
        moh      = N'(1) << mi;
        m_c      = 32'(CW'(cnt >> (mi * CW)));
        m_g      = cyc;
        m_end    = cyc + m_c * P + GAP;
        m_ptr    = mi;
        m_active = 1'b1;
        gq.push_back('{cyc, moh});
      end
      exp_busy = m_active;
    end
  end

  // Monitor: pops expectations when the DUT presents them, flags missing ones.
  always @(negedge clk) begin
    if (reset) begin
      if (gnt != '0) begin
        if (gq.size() == 0) begin
          chk("gnt_unexpected", 32'(gnt), 0);
        end else begin
          ge = gq.pop_front();
          chk("gnt_onehot", 32'(gnt), 32'(ge.oh));
          chk("gnt_cycle", cyc, ge.cyc);
          last_g = cyc;
        end
      end else if (gq.size() != 0 && gq[0].cyc <= cyc) begin
        ge = gq.pop_front();
        chk("gnt_missing", 0, 32'(ge.oh));
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("done_unexpected", 1, 0);
        end else begin
          de = dq.pop_front();
          chk("done_cycle", cyc, de);
          last_d = cyc;
        end
      end else if (dq.size() != 0 && dq[0] <= cyc) begin
        de = dq.pop_front();
        chk("done_missing", 0, 1);
      end
      chk("out", 32'(out), 32'(exp_out));
      chk("busy", 32'(busy), 32'(exp_busy));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 400) begin
      step(1);
      k++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req   = '0;
    cnt   = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out",  32'(out),  0);
    chk("rst_gnt",  32'(gnt),  0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b1;

    // Idle with no requests.
    step(20);

    // Two-blink burst from requester 0.
    req = 4'b0001;
    cnt = 16'h0002;
    step(1);
    req = '0;
    wait_idle();
    step(2);
    chk("t2_burst_len", last_d - last_g, 24);

    // All requesting, one blink each: rotation and one idle cycle between bursts.
    req = 4'b1111;
    cnt = 16'h1111;
    step(70);
    req = '0;
    wait_idle();
    step(2);

    // Zero-count burst: gap only.
    req = 4'b0100;
    cnt = 16'h0000;
    step(1);
    req = '0;
    wait_idle();
    step(2);
    chk("t4_burst_len", last_d - last_g, 8);

    // Reset in the second ON cycle, then the pointer restarts from the top.
    req = 4'b0001;
    cnt = 16'h0003;
    step(2);
    chk("t5_out_before_rst", 32'(out), 1);
    reset = 1'b0;
    #1;
    chk("t5_out_async", 32'(out), 0);
    chk("t5_busy_async", 32'(busy), 0);
    req = 4'b1010;
    step(1);
    reset = 1'b1;
    step(1);
    chk("t5_first_gnt", 32'(gnt), 32'(4'b0010));
    req = '0;
    wait_idle();
    step(2);

    // Single-cycle request still runs the full burst; later requests wait for done.
    req = 4'b0001;
    cnt = 16'h2223;
    step(1);
    req = '0;
    step(5);
    req = 4'b1110;
    step(1);
    chk("t6_busy_held", 32'(busy), 1);
    step(110);
    req = '0;
    wait_idle();
    step(2);

    // Randomized traffic with occasional asynchronous resets.
    for (int it = 0; it < 60; it++) begin
      req = N'($urandom_range(0, 15));
      cnt = 16'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b0;
        #1;
        chk("rnd_rst_out", 32'(out), 0);
        chk("rnd_rst_busy", 32'(busy), 0);
        step(1);
        reset = 1'b1;
      end
      step($urandom_range(1, 30));
    end
    req = '0;
    wait_idle();
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
